msk_skinny_round_ctrl: RTL and testbench

Round scheduler for the masked Skinny-128 core. Sequences one encryption: loads the shared state, drives the multi-cycle masked SubCells pipeline, then commits the linear layer (AddConstants, AddRoundTweakey, ShiftRows, MixColumns) and the tweakey update once per round. Generates the 6-bit round constant. Gates S-box progress on fresh-randomness availability. Sits between the mode-level controller (start/done) and the masked round datapath. It carries control only; no shares pass through it.

---
 rtl/msk_skinny_pkg.sv | 26 ++
 rtl/msk_skinny_rc_lfsr.sv | 32 +++
 rtl/msk_skinny_round_ctrl.sv | 134 +++++++++++++
 tb/tb_msk_skinny_round_ctrl.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/msk_skinny_pkg.sv
// Shared definitions for the masked Skinny-128 round control and datapath.
//   state_e          : round scheduler FSM states
//   RC_INIT          : round constant of round 0
//   rc_next()        : 6-bit round-constant LFSR step
//   *_DEFAULT consts : default share count, round count and S-box latency
package msk_skinny_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LOAD = 3'd1,
    ST_SBOX = 3'd2,
    ST_LIN  = 3'd3,
    ST_DONE = 3'd4
  } state_e;

  localparam logic [5:0]  RC_INIT          = 6'h01;
  localparam int unsigned D_DEFAULT        = 2;
  localparam int unsigned ROUNDS_DEFAULT   = 48;
  localparam int unsigned SBOX_LAT_DEFAULT = 4;

  // Skinny round-constant LFSR: shift left, feed back rc5 ^ rc4 ^ 1.
  function automatic logic [5:0] rc_next(input logic [5:0] rc);
    return {rc[4:0], rc[5] ^ rc[4] ^ 1'b1};
  endfunction

endpackage

// File: rtl/msk_skinny_rc_lfsr.sv
// 6-bit round-constant generator for Skinny-128.
//   clk     : clock, rising edge
//   rst_n   : asynchronous active-low reset, clears the constant to 0
//   load_i  : load RC_INIT (start of an encryption)
//   step_i  : advance to the next round constant
//   rc_o    : current round constant
module msk_skinny_rc_lfsr
  import msk_skinny_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load_i,
  input  logic       step_i,
  output logic [5:0] rc_o
);

  logic [5:0] rc_q;

  // load has priority so a new encryption always starts from RC_INIT
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rc_q <= 6'h00;
    end else if (load_i) begin
      rc_q <= RC_INIT;
    end else if (step_i) begin
      rc_q <= rc_next(rc_q);
    end
  end

  assign rc_o = rc_q;

endmodule

// File: rtl/msk_skinny_round_ctrl.sv
// Round scheduler for the masked Skinny-128 core. Control only; no shares.
//   clk, rst_n   : clock, asynchronous active-low reset
//   start        : begin an encryption (taken only in IDLE)
//   rnd_valid    : fresh randomness present this cycle
//   busy         : registered, LOAD through DONE
//   load_state   : datapath captures the input sharing
//   sb_en        : advance the masked S-box pipeline one stage
//   rnd_req      : S-box layer wants randomness
//   lin_en       : datapath captures the linear-layer result
//   tk_update    : tweakey schedule steps one round
//   rc           : current round constant
//   round_cnt    : current round index (0-based)
//   last_round   : round_cnt == ROUNDS-1
//   done         : one-cycle pulse, ciphertext sharing valid
//   dbg_state_o  : current FSM state for observation
//
// Randomness handshake: rnd_req is the ready side and rnd_valid the valid
// side; a randomness word is consumed exactly in cycles where both are high,
// which is also the only time the S-box pipeline advances (sb_en).
module msk_skinny_round_ctrl
  import msk_skinny_pkg::*;
#(
  parameter int unsigned d        = D_DEFAULT,
  parameter int unsigned ROUNDS   = ROUNDS_DEFAULT,
  parameter int unsigned SBOX_LAT = SBOX_LAT_DEFAULT
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       rnd_valid,
  output logic       busy,
  output logic       load_state,
  output logic       sb_en,
  output logic       rnd_req,
  output logic       lin_en,
  output logic       tk_update,
  output logic [5:0] rc,
  output logic [5:0] round_cnt,
  output logic       last_round,
  output logic       done,
  output state_e     dbg_state_o
);

  localparam logic [5:0] LAST_RND = 6'(ROUNDS - 1);
  localparam logic [3:0] SB_LAST  = 4'(SBOX_LAT - 1);

  if (d < 1) begin : g_bad_d
    $error("msk_skinny_round_ctrl: share count d must be at least 1");
  end
  if (ROUNDS < 1 || ROUNDS > 63) begin : g_bad_rounds
    $error("msk_skinny_round_ctrl: ROUNDS must be in 1..63");
  end
  if (SBOX_LAT < 1 || SBOX_LAT > 15) begin : g_bad_lat
    $error("msk_skinny_round_ctrl: SBOX_LAT must be in 1..15");
  end

  state_e     state_q, state_d;
  logic [5:0] round_cnt_q;
  logic [3:0] sb_cnt_q;
  logic       last_round_q;
  logic       busy_q;
  logic       rc_load, rc_step;

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (start) state_d = ST_LOAD;
      ST_LOAD: state_d = ST_SBOX;
      ST_SBOX: if (rnd_valid && (sb_cnt_q == SB_LAST)) state_d = ST_LIN;
      ST_LIN:  state_d = last_round_q ? ST_DONE : ST_SBOX;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // State and round bookkeeping. last_round is kept as a register so it
  // reads 0 out of reset even when ROUNDS == 1, and holds after DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      round_cnt_q  <= 6'd0;
      sb_cnt_q     <= 4'd0;
      last_round_q <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q <= state_d;
      busy_q  <= (state_d != ST_IDLE);
      unique case (state_q)
        ST_LOAD: begin
          round_cnt_q  <= 6'd0;
          sb_cnt_q     <= 4'd0;
          last_round_q <= (LAST_RND == 6'd0);
        end
        ST_SBOX: begin
          if (rnd_valid) begin
            sb_cnt_q <= (sb_cnt_q == SB_LAST) ? 4'd0 : sb_cnt_q + 4'd1;
          end
        end
        ST_LIN: begin
          if (!last_round_q) begin
            round_cnt_q  <= round_cnt_q + 6'd1;
            last_round_q <= ((round_cnt_q + 6'd1) == LAST_RND);
          end
        end
        default: ;
      endcase
    end
  end

  assign rc_load = (state_q == ST_LOAD);
  assign rc_step = (state_q == ST_LIN) && !last_round_q;

  msk_skinny_rc_lfsr u_rc_lfsr (
    .clk    (clk),
    .rst_n  (rst_n),
    .load_i (rc_load),
    .step_i (rc_step),
    .rc_o   (rc)
  );

  // Strobes are pure state decodes; only sb_en also looks at rnd_valid.
  assign load_state  = (state_q == ST_LOAD);
  assign rnd_req     = (state_q == ST_SBOX);
  assign sb_en       = rnd_req & rnd_valid;
  assign lin_en      = (state_q == ST_LIN);
  assign tk_update   = (state_q == ST_LIN);
  assign done        = (state_q == ST_DONE);
  assign busy        = busy_q;
  assign round_cnt   = round_cnt_q;
  assign last_round  = last_round_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_msk_skinny_round_ctrl.sv
module tb_msk_skinny_round_ctrl;
  import msk_skinny_pkg::*;

  localparam int R       = 48;
  localparam int L       = 4;
  localparam int RUN_LEN = 2 + R * (L + 1);  // accept cycle -> done cycle

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst_n;
  int   cyc;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- DUTs ----------------
  logic       start, start_s, rnd_valid;
  logic       busy, load_state, sb_en, rnd_req, lin_en, tk_update, last_round, done;
  logic [5:0] rc, round_cnt;
  state_e     dbg_state;
  logic       busy_s, load_state_s, sb_en_s, rnd_req_s, lin_en_s, tk_update_s;
  logic       last_round_s, done_s;
  logic [5:0] rc_s, round_cnt_s;
  state_e     dbg_state_s;

  msk_skinny_round_ctrl #(.d(2), .ROUNDS(R), .SBOX_LAT(L)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .rnd_valid(rnd_valid),
    .busy(busy), .load_state(load_state), .sb_en(sb_en), .rnd_req(rnd_req),
    .lin_en(lin_en), .tk_update(tk_update), .rc(rc), .round_cnt(round_cnt),
    .last_round(last_round), .done(done), .dbg_state_o(dbg_state)
  );

  msk_skinny_round_ctrl #(.d(2), .ROUNDS(1), .SBOX_LAT(1)) u_small (
    .clk(clk), .rst_n(rst_n), .start(start_s), .rnd_valid(rnd_valid),
    .busy(busy_s), .load_state(load_state_s), .sb_en(sb_en_s), .rnd_req(rnd_req_s),
    .lin_en(lin_en_s), .tk_update(tk_update_s), .rc(rc_s), .round_cnt(round_cnt_s),
    .last_round(last_round_s), .done(done_s), .dbg_state_o(dbg_state_s)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_err    = 0;

  logic [5:0] exp_q[$];       // expected rc per lin_en
  logic [5:0] rc_seen[$];     // rc observed at each lin_en
  int         sb_per_round[$];
  int         done_q[$];
  int         sb_since;
  int         excl_bad;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [5:0] rc_model(input logic [5:0] r);
    return {r[4:0], ~(r[5] ^ r[4])};
  endfunction

  // Passive monitor on the default-parameter DUT, sampled on the falling edge.
  always @(negedge clk) begin
    if (rst_n) begin
      if (lin_en) begin
        rc_seen.push_back(rc);
        sb_per_round.push_back(sb_since);
        sb_since = 0;
      end
      if (sb_en) sb_since++;
      if (done) done_q.push_back(cyc);
      if ((int'(load_state) + int'(sb_en) + int'(lin_en) + int'(done)) > 1) excl_bad++;
      if (lin_en != tk_update) excl_bad++;
      if (sb_en && !rnd_req) excl_bad++;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic clear_mon();
    exp_q.delete();
    rc_seen.delete();
    sb_per_round.delete();
    done_q.delete();
    sb_since = 0;
    excl_bad = 0;
  endtask

  // Returns just after the rising edge that begins cycle t.
  task automatic goto_cycle(input int t);
    while (cyc < t) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Raises start for one cycle; k is the cycle whose closing edge accepts it.
  task automatic pulse_start(output int k);
    @(posedge clk);
    #1;
    start = 1'b1;
    k = cyc;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int n, input int budget);
    int i;
    i = 0;
    while (done_q.size() < n && i < budget) begin
      @(posedge clk);
      #1;
      i++;
    end
    check_eq("done_within_budget", 32'(done_q.size() >= n), 32'd1);
  endtask

  task automatic check_idle_outputs(input string tag);
    check_eq({tag, "_busy"},       32'(busy),       32'd0);
    check_eq({tag, "_load_state"}, 32'(load_state), 32'd0);
    check_eq({tag, "_sb_en"},      32'(sb_en),      32'd0);
    check_eq({tag, "_rnd_req"},    32'(rnd_req),    32'd0);
    check_eq({tag, "_lin_en"},     32'(lin_en),     32'd0);
    check_eq({tag, "_tk_update"},  32'(tk_update),  32'd0);
    check_eq({tag, "_done"},       32'(done),       32'd0);
    check_eq({tag, "_rc"},         32'(rc),         32'd0);
    check_eq({tag, "_round_cnt"},  32'(round_cnt),  32'd0);
    check_eq({tag, "_last_round"}, 32'(last_round), 32'd0);
    check_eq({tag, "_state"},      32'(dbg_state),  32'(ST_IDLE));
  endtask

  // Full rc trajectory against the LFSR model, first seven against a hand table.
  task automatic check_rc_run(input string tag);
    logic [5:0] m;
    logic [5:0] hand [7];
    int         bad_sb;
    hand = '{6'h01, 6'h03, 6'h07, 6'h0F, 6'h1F, 6'h3E, 6'h3D};
    m = 6'h01;
    for (int i = 0; i < R; i++) begin
      exp_q.push_back(m);
      m = rc_model(m);
    end
    check_eq({tag, "_lin_count"}, 32'(rc_seen.size()), 32'(R));
    for (int i = 0; i < 7 && i < rc_seen.size(); i++)
      check_eq({tag, "_rc_hand"}, 32'(rc_seen[i]), 32'(hand[i]));
    for (int i = 0; i < rc_seen.size(); i++) begin
      m = exp_q.pop_front();
      check_eq({tag, "_rc_model"}, 32'(rc_seen[i]), 32'(m));
    end
    bad_sb = 0;
    foreach (sb_per_round[i]) if (sb_per_round[i] != L) bad_sb++;
    check_eq({tag, "_sb_per_round_bad"}, 32'(bad_sb), 32'd0);
    check_eq({tag, "_exclusive_bad"}, 32'(excl_bad), 32'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int         k;
    logic [5:0] rc_last;
    state_e     exp_st [4];

    rst_n = 1'b0; start = 1'b0; start_s = 1'b0; rnd_valid = 1'b1;
    clear_mon();
    repeat (3) @(negedge clk);
    check_idle_outputs("reset");
    check_eq("reset_small_last_round", 32'(last_round_s), 32'd0);
    @(posedge clk); #3;
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // Run 1: no stalls, with a stray start at accept+100.
    clear_mon();
    pulse_start(k);
    @(negedge clk);
    check_eq("r1_load_state", 32'(load_state), 32'd1);
    check_eq("r1_busy_load",  32'(busy),       32'd1);
    check_eq("r1_state_load", 32'(dbg_state),  32'(ST_LOAD));
    goto_cycle(k + 100);
    start = 1'b1;
    goto_cycle(k + 101);
    start = 1'b0;
    check_eq("r1_busy_mid", 32'(busy), 32'd1);
    wait_done(1, RUN_LEN + 20);
    check_eq("r1_done_cycle", 32'(done_q.size() > 0 ? done_q[0] - k : -1), 32'(RUN_LEN));
    check_rc_run("r1");
    rc_last = 6'h01;
    for (int i = 1; i < R; i++) rc_last = rc_model(rc_last);
    @(negedge clk);
    check_eq("r1_idle_busy",       32'(busy),       32'd0);
    check_eq("r1_idle_state",      32'(dbg_state),  32'(ST_IDLE));
    check_eq("r1_hold_round_cnt",  32'(round_cnt),  32'(R - 1));
    check_eq("r1_hold_last_round", 32'(last_round), 32'd1);
    check_eq("r1_hold_rc",         32'(rc),         32'(rc_last));

    // Run 2: rnd_valid low for three cycles in the second SBOX cycle of round 5.
    clear_mon();
    pulse_start(k);
    goto_cycle(k + 2 + 5 * (L + 1) + 1);
    rnd_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_eq("r2_stall_sb_en",     32'(sb_en),     32'd0);
      check_eq("r2_stall_rnd_req",   32'(rnd_req),   32'd1);
      check_eq("r2_stall_round_cnt", 32'(round_cnt), 32'd5);
      @(posedge clk);
      #1;
    end
    rnd_valid = 1'b1;
    wait_done(1, RUN_LEN + 20);
    check_eq("r2_done_cycle", 32'(done_q.size() > 0 ? done_q[0] - k : -1), 32'(RUN_LEN + 3));
    check_rc_run("r2");

    // Run 3: start held high. Between done pulses: IDLE, LOAD, rounds, DONE.
    clear_mon();
    @(posedge clk); #1;
    start = 1'b1;
    k = cyc;
    wait_done(2, 2 * RUN_LEN + 40);
    start = 1'b0;
    check_eq("r3_first_done", 32'(done_q.size() > 0 ? done_q[0] - k : -1), 32'(RUN_LEN));
    check_eq("r3_done_gap", 32'(done_q.size() > 1 ? done_q[1] - done_q[0] : -1),
             32'(R * (L + 1) + 3));
    check_eq("r3_lin_count", 32'(rc_seen.size()), 32'(2 * R));
    @(negedge clk);
    check_eq("r3_idle_busy", 32'(busy), 32'd0);

    // Run 4: asynchronous reset in the middle of round 20, then a clean run.
    clear_mon();
    pulse_start(k);
    goto_cycle(k + 2 + 20 * (L + 1) + 2);
    @(negedge clk);
    check_eq("r4_pre_round_cnt", 32'(round_cnt), 32'd20);
    #2;
    rst_n = 1'b0;
    #1;
    check_idle_outputs("r4_async");
    @(posedge clk); #3;
    rst_n = 1'b1;
    clear_mon();
    pulse_start(k);
    wait_done(1, RUN_LEN + 20);
    check_eq("r4_done_cycle", 32'(done_q.size() > 0 ? done_q[0] - k : -1), 32'(RUN_LEN));
    check_rc_run("r4");

    // Run 5: ROUNDS=1, SBOX_LAT=1 instance.
    exp_st = '{ST_LOAD, ST_SBOX, ST_LIN, ST_DONE};
    @(posedge clk); #1;
    start_s = 1'b1;
    @(posedge clk); #1;
    start_s = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check_eq("r5_state", 32'(dbg_state_s), 32'(exp_st[i]));
      check_eq("r5_done",  32'(done_s), 32'(i == 3));
      if (i == 1 || i == 2) check_eq("r5_last_round", 32'(last_round_s), 32'd1);
      @(posedge clk); #1;
    end
    @(negedge clk);
    check_eq("r5_idle_state", 32'(dbg_state_s), 32'(ST_IDLE));
    check_eq("r5_idle_busy",  32'(busy_s), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish (checks %0d, errors %0d)", n_checks, n_err);
    $fatal(1, "watchdog expired");
  end

endmodule
